conv_tap_sequencer: RTL and testbench
=====================================

# conv_tap_sequencer

Controller that time-multiplexes one multiply core across all taps of a K×K convolution window. It holds the kernel coefficients in a local register file. For each input pixel it drives the core's select, load, data and kernel lines, then accumulates the signed products into one window result. Results leave on a valid/ready stream. It sits between the pixel/config streams and a single `core` instance (16-bit registered operands, combinational Booth product).

## Interface
Parameters:
- `W`, 16, operand width (pixel and coefficient), two's complement.
- `TAPS`, 9, taps per window (3×3).
- `ACC_W`, 2*W+4, accumulator width; must be ≥ 2*W+clog2(TAPS).

Ports:
- `clk_`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`, `cfg_ready`, `cfg_data`  in/out/in  1/1/W  coefficient stream, tap order 0..TAPS-1.
- `in_valid`, `in_ready`, `in_data`  in/out/in  1/1/W  pixel stream, TAPS words per window, tap order.
- `out_valid`, `out_ready`, `out_data`  out/in/out  1/1/ACC_W  window result stream.
- `core_sel`, `core_d_load`, `core_k_load`  out  1  core control.
- `core_data`, `core_kernel`  out  W  core operands.
- `core_prod`  in  2*W  core product, signed.
- `busy`  out  1  window in progress or result pending.

## Operation
- States:
  - S_CFG: `cfg_ready`=1. Each cfg handshake writes `kreg[cfg_cnt]`. After TAPS words go to S_RUN and reset `cfg_cnt` to 0.
  - S_RUN: `in_ready`=1. An in handshake ("accept") drives the core: `core_sel`=`core_d_load`=`core_k_load`=1, `core_data`=`in_data`, `core_kernel`=`kreg[tap_cnt]`.
    - Each accept sets the `pend` flag and increments `tap_cnt`.
    - When the accepted tap is TAPS-1, wrap `tap_cnt` to 0 and go to S_ACC.
  - S_ACC: one cycle, `in_ready`=0. The last product is accumulated here. Then go to S_OUT.
  - S_OUT: `out_valid`=1 and `out_data`=acc. On `out_ready`, go to S_RUN.
- Accumulate: in the cycle after an accept (`pend`=1), add `core_prod`, sign-extended to ACC_W, to acc. Clear `pend` after the add.
  - On tap 0 of a window, acc is loaded with the product instead of added.
  - No saturation. ACC_W cannot overflow.
- Stalls: if `in_valid`=0 in S_RUN, hold `core_sel`=0. The core registers hold their value, so `core_prod` stays stable and nothing is re-accumulated.
- Reconfiguration: in S_RUN with `tap_cnt`=0, `pend`=0 and `cfg_valid`=1, cfg has priority.
  - Force `in_ready`=0 and go to S_CFG.
  - The first cfg word is accepted in the following cycle.
  - A full TAPS-word reload is required.
- Reset (`rst`=1, any state):
  - Next state is S_CFG.
  - `cfg_cnt`, `tap_cnt`, `pend` and acc are set to 0, and `kreg` is cleared.
  - `core_sel`=1 and the load lines are 0 so the core clears its own registers.
  - A window in progress is discarded. No output is produced for it.
- Outputs while `rst`=1: `cfg_ready`, `in_ready`, `out_valid` and `busy` are 0, and `out_data`=0.
- `busy` = (S_RUN and (`tap_cnt`≠0 or `pend`)) or S_ACC or S_OUT.

## Timing
- Accept of tap k at cycle t: core operand registers update at the end of t, `core_prod` is valid during t+1, acc updates at the end of t+1.
- Last tap accepted at cycle t: accumulated in S_ACC at t+1, `out_valid`=1 from t+2.
- Minimum window period is TAPS+2 cycles with no stalls and `out_ready` held high.
- `out_data` and `out_valid` stay stable while `out_ready`=0. `in_ready` stays 0 until the result handshake.
- Pixel tap 0 of the next window can be accepted in the cycle after the out handshake.
- A cfg word and an in word are never accepted in the same cycle.

## Structure
- Shared package `conv_pkg` holds the state encoding `conv_state_t` (S_CFG, S_RUN, S_ACC, S_OUT) and the defaults for W, TAPS and ACC_W.
- Natural sub-module: `kernel_regfile`, a TAPS×W register file with one write port, one read port and a synchronous clear.
- The single multiply `core` is instantiated outside this block and connected through the `core_*` ports.

## Test plan
- Config coefficients 1×9, pixels 1..9, `out_ready`=1 -> `out_data`=45, `out_valid` 2 cycles after the 9th accept, window period 11 cycles.
- Coefficients -32768 ×9, pixels -32768 ×9 -> `out_data`=9663676416 (36-bit signed), no wrap. Coefficients alternating ±1 with pixels 100 -> `out_data`=100.
- Random `in_valid` bubbles between taps (coefficients 1..9, pixels 9..1) -> `out_data`=165, identical to the no-bubble run; `core_sel`=0 during bubbles.
- `out_ready` low for 5 cycles -> `out_data`/`out_valid` held, `in_ready`=0, `busy`=1. Next window starts the cycle after the handshake.
- `cfg_valid` at `tap_cnt`=0 with `in_valid` also high -> `in_ready`=0, state S_CFG. Reload coefficients 2×9 with pixels 1..9 -> 90.
- `rst` pulsed after tap 4 -> no output, `cfg_ready`=1 the cycle after `rst` falls. Pixels sent without reconfig -> 0 until 9 coefficients are loaded.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution tap sequencer.
package conv_pkg;

    localparam int CONV_W     = 16;
    localparam int CONV_TAPS  = 9;
    localparam int CONV_ACC_W = 2 * CONV_W + 4;

    typedef enum logic [1:0] {
        S_CFG = 2'd0,
        S_RUN = 2'd1,
        S_ACC = 2'd2,
        S_OUT = 2'd3
    } conv_state_t;

endpackage

// File: rtl/kernel_regfile.sv
// Kernel coefficient store: one write port, one combinational read port,
// synchronous clear.
module kernel_regfile
    import conv_pkg::*;
#(
    parameter int W     = CONV_W,
    parameter int DEPTH = CONV_TAPS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk_) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= rst ? '0 : mem_d[i];
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/conv_tap_sequencer.sv
// Drives a shared multiply core through every tap of a KxK window and
// accumulates the signed products into one streamed result.
module conv_tap_sequencer
    import conv_pkg::*;
#(
    parameter int W     = CONV_W,
    parameter int TAPS  = CONV_TAPS,
    parameter int ACC_W = CONV_ACC_W
) (
    input  logic               clk_,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [W-1:0]       cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               core_sel,
    output logic               core_d_load,
    output logic               core_k_load,
    output logic [W-1:0]       core_data,
    output logic [W-1:0]       core_kernel,
    input  logic [2*W-1:0]     core_prod,
    output logic               busy
);

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    conv_state_t      state_q, state_d;
    logic [CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    logic             pend_q, pend_d;
    logic             first_q, first_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_ext;
    logic             kreg_we;
    logic [W-1:0]     kreg_rd;

    assign prod_ext = {{(ACC_W - 2*W){core_prod[2*W-1]}}, core_prod};

    kernel_regfile #(
        .W     (W),
        .DEPTH (TAPS),
        .AW    (CNT_W)
    ) u_kreg (
        .clk_    (clk_),
        .rst     (rst),
        .wr_en   (kreg_we),
        .wr_addr (cfg_cnt_q),
        .wr_data (cfg_data),
        .rd_addr (tap_cnt_q),
        .rd_data (kreg_rd)
    );

    always_comb begin
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        tap_cnt_d   = tap_cnt_q;
        pend_d      = pend_q;
        first_d     = first_q;
        acc_d       = acc_q;
        kreg_we     = 1'b0;
        cfg_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        core_sel    = 1'b0;
        core_d_load = 1'b0;
        core_k_load = 1'b0;
        core_data   = in_data;
        core_kernel = kreg_rd;
        busy        = 1'b0;

        // Product of the previous cycle's accept is on core_prod now.
        if (pend_q) begin
            acc_d  = first_q ? prod_ext : acc_q + prod_ext;
            pend_d = 1'b0;
        end

        case (state_q)
            S_CFG: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    kreg_we = 1'b1;
                    if (cfg_cnt_q == LAST_TAP) begin
                        cfg_cnt_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                busy = (tap_cnt_q != '0) || pend_q;
                if ((tap_cnt_q == '0) && !pend_q && cfg_valid) begin
                    state_d = S_CFG;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        core_sel    = 1'b1;
                        core_d_load = 1'b1;
                        core_k_load = 1'b1;
                        pend_d      = 1'b1;
                        first_d     = (tap_cnt_q == '0);
                        if (tap_cnt_q == LAST_TAP) begin
                            tap_cnt_d = '0;
                            state_d   = S_ACC;
                        end else begin
                            tap_cnt_d = tap_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_ACC: begin
                busy    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_CFG;
        endcase

        // Reset: quiet handshakes, core clears its own operand registers.
        if (rst) begin
            kreg_we     = 1'b0;
            cfg_ready   = 1'b0;
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            out_data    = '0;
            busy        = 1'b0;
            core_sel    = 1'b1;
            core_d_load = 1'b0;
            core_k_load = 1'b0;
        end
    end

    always_ff @(posedge clk_) begin
        if (rst) begin
            state_q   <= S_CFG;
            cfg_cnt_q <= '0;
            tap_cnt_q <= '0;
            pend_q    <= 1'b0;
            first_q   <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cfg_cnt_q <= cfg_cnt_d;
            tap_cnt_q <= tap_cnt_d;
            pend_q    <= pend_d;
            first_q   <= first_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed bench for conv_tap_sequencer with a behavioural multiply core.
module tb_conv_tap_sequencer;
    import conv_pkg::*;

    logic        clk_ = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_data;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [35:0] out_data;
    logic        core_sel, core_d_load, core_k_load;
    logic [15:0] core_data, core_kernel;
    logic [31:0] core_prod;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [35:0] out_q[$];
    int          out_cyc_q[$];
    int          acc_cyc_q[$];

    conv_tap_sequencer dut (
        .clk_(clk_), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_sel(core_sel), .core_d_load(core_d_load), .core_k_load(core_k_load),
        .core_data(core_data), .core_kernel(core_kernel), .core_prod(core_prod),
        .busy(busy)
    );

    // Behavioural core: registered operands, combinational signed product.
    logic signed [15:0] d_r, k_r;
    always @(posedge clk_) begin
        if (core_sel) begin
            if (!core_d_load && !core_k_load) begin
                d_r <= '0;
                k_r <= '0;
            end else begin
                if (core_d_load) d_r <= core_data;
                if (core_k_load) k_r <= core_kernel;
            end
        end
    end
    assign core_prod = d_r * k_r;

    always #5 clk_ = ~clk_;
    always @(posedge clk_) cyc <= cyc + 1;

    always @(negedge clk_) begin
        if (!rst && out_valid && out_ready) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
        end
        if (!rst && in_valid && in_ready) acc_cyc_q.push_back(cyc);
    end

    task automatic tick;
        @(posedge clk_);
        #1;
    endtask

    task automatic clear_q;
        out_q.delete();
        out_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic send_cfg(input logic [15:0] d);
        int n = 0;
        logic rdy;
        cfg_valid = 1'b1;
        cfg_data  = d;
        do begin
            #1;
            rdy = cfg_ready;
            tick();
            n++;
        end while (!rdy && n < 40);
        cfg_valid = 1'b0;
        if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL cfg_accept_timeout: word %0h never accepted", d);
        end
    endtask

    task automatic send_pixel(input logic [15:0] d);
        int n = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            #1;
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 40);
        in_valid = 1'b0;
        if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL pixel_accept_timeout: pixel %0h never accepted", d);
        end
    endtask

    task automatic wait_out(input int cnt, output bit ok);
        int n = 0;
        while (out_q.size() < cnt && n < 40) begin
            tick();
            n++;
        end
        ok = (out_q.size() >= cnt);
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_data = '0; in_data = '0;
        repeat (2) tick();
        #1;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (out_data !== 36'd0) begin n_fail++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
        n_checks++; if ({core_sel, core_d_load, core_k_load} !== 3'b100) begin n_fail++; $display("FAIL rst_core_ctl: got %b want 100", {core_sel, core_d_load, core_k_load}); end
        rst = 1'b0;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cfg_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_basic;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_cfg(16'd1);
        clear_q();
        for (int i = 1; i <= 9; i++) send_pixel(16'(i));
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd45) begin n_fail++; $display("FAIL basic_sum: got %0d want 45 (ok=%0b)", ok ? out_q[0] : 36'd0, ok); end
        n_checks++; if (!ok || out_cyc_q[0] - acc_cyc_q[8] != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", ok ? out_cyc_q[0] - acc_cyc_q[8] : -1); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        clear_q();
        for (int w = 0; w < 2; w++)
            for (int i = 1; i <= 9; i++) send_pixel(16'(i));
        wait_out(2, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd45 || out_q[1] !== 36'd45) begin n_fail++; $display("FAIL b2b_sums: got %0d/%0d want 45/45", ok ? out_q[0] : 0, ok ? out_q[1] : 0); end
        n_checks++; if (acc_cyc_q[9] - acc_cyc_q[0] != 11) begin n_fail++; $display("FAIL b2b_period: got %0d want 11", acc_cyc_q[9] - acc_cyc_q[0]); end
    endtask

    task automatic test_extremes;
        bit ok;
        for (int i = 0; i < 9; i++) send_cfg(16'h8000);
        clear_q();
        for (int i = 0; i < 9; i++) send_pixel(16'h8000);
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd9663676416) begin n_fail++; $display("FAIL extreme_sum: got %0d want 9663676416", ok ? out_q[0] : 0); end
        // Force reconfiguration by presenting cfg at tap 0.
        for (int i = 0; i < 9; i++) send_cfg((i % 2 == 0) ? 16'd1 : 16'hFFFF);
        clear_q();
        for (int i = 0; i < 9; i++) send_pixel(16'd100);
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd100) begin n_fail++; $display("FAIL alt_sign_sum: got %0d want 100", ok ? out_q[0] : 0); end
    endtask

    task automatic test_bubbles;
        bit ok;
        int b;
        for (int i = 1; i <= 9; i++) send_cfg(16'(i));
        clear_q();
        for (int i = 0; i < 9; i++) begin
            b = (i == 0) ? 0 : int'($urandom_range(1, 3));
            for (int j = 0; j < b; j++) begin
                #1;
                n_checks++; if (core_sel !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bubble_core_sel: core_sel=%b busy=%b want 0/1", core_sel, busy); end
                tick();
            end
            send_pixel(16'(9 - i));
        end
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd165) begin n_fail++; $display("FAIL bubble_sum: got %0d want 165", ok ? out_q[0] : 0); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n = 0;
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_pixel(16'(i));
        clear_q();
        while (out_valid !== 1'b1 && n < 10) begin tick(); #1; n++; end
        in_valid = 1'b1;
        in_data  = 16'd7;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== 36'd285 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL hold_out: valid=%b data=%0d in_ready=%b busy=%b want 1/285/0/1", out_valid, out_data, in_ready, busy);
            end
        end
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send_pixel(16'd7);
        wait_out(2, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd285 || out_q[1] !== 36'd315) begin n_fail++; $display("FAIL bp_sums: got %0d/%0d want 285/315", ok ? out_q[0] : 0, ok ? out_q[1] : 0); end
        n_checks++; if (acc_cyc_q.size() == 0 || acc_cyc_q[0] - out_cyc_q[0] != 1) begin n_fail++; $display("FAIL bp_restart: got %0d want 1", acc_cyc_q.size() > 0 ? acc_cyc_q[0] - out_cyc_q[0] : -1); end
    endtask

    task automatic test_reconfig;
        bit ok;
        clear_q();
        cfg_valid = 1'b1; cfg_data = 16'd2;
        in_valid  = 1'b1; in_data  = 16'd1;
        #1;
        n_checks++; if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reconf_prio: in_ready=%b cfg_ready=%b want 0/0", in_ready, cfg_ready); end
        tick();
        n_checks++; if (dut.state_q !== S_CFG || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_state: state=%0d cfg_ready=%b want %0d/1", dut.state_q, cfg_ready, S_CFG); end
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) send_cfg(16'd2);
        #1;
        n_checks++; if (acc_cyc_q.size() != 0 || cfg_ready !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_done: accepts=%0d cfg_ready=%b in_ready=%b want 0/0/1", acc_cyc_q.size(), cfg_ready, in_ready); end
        for (int i = 1; i <= 9; i++) send_pixel(16'(i));
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd90) begin n_fail++; $display("FAIL reconf_sum: got %0d want 90", ok ? out_q[0] : 0); end
    endtask

    task automatic test_reset_midwindow;
        bit ok;
        clear_q();
        for (int i = 1; i <= 5; i++) send_pixel(16'(i));
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || core_sel !== 1'b1) begin n_fail++; $display("FAIL mid_rst_outputs: busy=%b in_ready=%b core_sel=%b want 0/0/1", busy, in_ready, core_sel); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cfg_ready: got %b want 1", cfg_ready); end
        in_valid = 1'b1; in_data = 16'd5;
        repeat (6) tick();
        in_valid = 1'b0;
        n_checks++; if (out_q.size() != 0 || acc_cyc_q.size() != 5) begin n_fail++; $display("FAIL mid_rst_discard: outs=%0d accepts=%0d want 0/5", out_q.size(), acc_cyc_q.size()); end
        for (int i = 0; i < 8; i++) send_cfg(16'd3);
        #1;
        n_checks++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL partial_cfg: cfg_ready=%b in_ready=%b want 1/0", cfg_ready, in_ready); end
        send_cfg(16'd3);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_cfg_in_ready: got %b want 1", in_ready); end
        for (int i = 1; i <= 9; i++) send_pixel(16'(i));
        wait_out(1, ok);
        n_checks++; if (!ok || out_q[0] !== 36'd135) begin n_fail++; $display("FAIL post_rst_sum: got %0d want 135", ok ? out_q[0] : 0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_bubbles();
        test_backpressure();
        test_reconfig();
        test_reset_midwindow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
